// File: rtl/wbs_reg_responder.sv
// Wishbone pipelined slave serving tagged bursts against a small 8-bit register file.
// Each accepted beat gets exactly one registered ack or err on the following cycle.
module wbs_reg_responder #(
  parameter int unsigned REG_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wbs_cyc_i,
  input  logic       wbs_stb_i,
  input  logic       wbs_we_i,
  input  logic [9:0] wbs_adr_i,
  input  logic [7:0] wbs_tga_i,
  input  logic [7:0] wbs_dat_i,
  input  logic       wbs_tgc_i,
  output logic [7:0] wbs_dat_o,
  output logic       wbs_stall_o,
  output logic       wbs_ack_o,
  output logic       wbs_err_o
);

  localparam int unsigned IdxW   = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [11:0] DepthL = 12'(REG_DEPTH);

  typedef enum logic [1:0] {StIdle, StBurst, StDone} state_e;

  state_e           state_q, state_d;
  logic [10:0]      addr_q, addr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic             tgc_q, tgc_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [7:0]       dat_q, dat_d;
  logic [7:0]       regs_q [REG_DEPTH];

  logic             accept;
  logic             stall;
  logic [10:0]      beat_addr;
  logic             beat_we;
  logic             beat_tgc;
  logic             beat_ok;
  logic             wr_en;
  logic [IdxW-1:0]  idx;
  logic [7:0]       rd_data;

  assign stall  = (state_q == StDone);
  assign accept = wbs_cyc_i & wbs_stb_i & ~stall;

  // The first beat uses the bus directly; later beats use the latched burst context.
  always_comb begin
    beat_addr = addr_q;
    beat_we   = we_q;
    beat_tgc  = tgc_q;
    if (state_q == StIdle) begin
      beat_addr = {1'b0, wbs_adr_i};
      beat_we   = wbs_we_i;
      beat_tgc  = wbs_tgc_i;
    end
  end

  assign beat_ok = beat_tgc & ({1'b0, beat_addr} < DepthL);
  assign idx     = beat_addr[IdxW-1:0];
  assign rd_data = beat_ok ? regs_q[idx] : 8'h00;
  assign wr_en   = accept & beat_ok & beat_we;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    tgc_d   = tgc_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = 8'h00;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = {1'b0, wbs_adr_i} + 11'd1;
          cnt_d   = wbs_tga_i;
          we_d    = wbs_we_i;
          tgc_d   = wbs_tgc_i;
          state_d = (wbs_tga_i == 8'd0) ? StDone : StBurst;
        end
      end
      StBurst: begin
        if (!wbs_cyc_i) begin
          state_d = StIdle;
        end else if (accept) begin
          addr_d = addr_q + 11'd1;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = StDone;
        end
      end
      StDone: begin
        if (!wbs_cyc_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      ack_d = beat_ok;
      err_d = ~beat_ok;
      dat_d = (beat_ok && !beat_we) ? rd_data : 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      tgc_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
      for (int i = 0; i < int'(REG_DEPTH); i++) regs_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      tgc_q   <= tgc_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
      if (wr_en) regs_q[idx] <= wbs_dat_i;
    end
  end

  assign wbs_stall_o = stall;
  assign wbs_ack_o   = ack_q;
  assign wbs_err_o   = err_q;
  assign wbs_dat_o   = dat_q;

endmodule

// File: tb/tb_wbs_reg_responder.sv
// Scoreboard bench for wbs_reg_responder: expected responses are queued as beats are
// driven and retired by a monitor as ack/err appear.
module tb_wbs_reg_responder;

  localparam int Depth = 16;

  logic       clk;
  logic       rst;
  logic       cyc;
  logic       stb;
  logic       we_i;
  logic [9:0] adr_i;
  logic [7:0] tga_i;
  logic [7:0] dat_i;
  logic       tgc_i;
  logic [7:0] dat_o;
  logic       stall;
  logic       ack;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;

  // {is_read, err, ack, dat}
  logic [10:0] sb [$];
  logic [7:0]  model_mem [Depth];
  logic [7:0]  wdata [16];

  wbs_reg_responder #(.REG_DEPTH(Depth)) dut (
    .clk         (clk),
    .rst         (rst),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we_i),
    .wbs_adr_i   (adr_i),
    .wbs_tga_i   (tga_i),
    .wbs_dat_i   (dat_i),
    .wbs_tgc_i   (tgc_i),
    .wbs_dat_o   (dat_o),
    .wbs_stall_o (stall),
    .wbs_ack_o   (ack),
    .wbs_err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst && (ack || err)) begin
      logic [10:0] e;
      n_checks++;
      if (ack && err) begin
        n_fail++;
        $display("FAIL both_ack_err: ack=%0b err=%0b, required exactly one", ack, err);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_resp: ack=%0b err=%0b, required no response", ack, err);
      end else begin
        e = sb.pop_front();
        if (ack !== e[8] || err !== e[9] ||
            ((e[10] || e[9]) && dat_o !== e[7:0])) begin
          n_fail++;
          $display("FAIL resp: got ack=%0b err=%0b dat=%02h, required ack=%0b err=%0b dat=%02h",
                   ack, err, dat_o, e[8], e[9], e[7:0]);
        end
      end
    end
  end

  // Drives one burst with stb held for nstb cycles, then drops cyc for one edge.
  task automatic do_burst(input bit we, input bit tgc, input int adr, input int tga,
                          input int nstb);
    cyc   = 1'b1;
    stb   = 1'b1;
    we_i  = we;
    tgc_i = tgc;
    adr_i = 10'(adr);
    tga_i = 8'(tga);
    for (int i = 0; i < nstb; i++) begin
      dat_i = wdata[i];
      if (i <= tga) begin
        int  a;
        bit  ok;
        a  = adr + i;
        ok = tgc && (a < Depth);
        if (ok && we) model_mem[a] = wdata[i];
        sb.push_back({!we, !ok, ok, (ok && !we) ? model_mem[a] : 8'h00});
      end
      n_checks++;
      if (stall !== 1'(i > tga)) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got %0b, required %0b", i, stall, (i > tga));
      end
      @(posedge clk); #1;
      // Mid-burst control changes must be ignored.
      we_i  = ~we;
      tgc_i = ~tgc;
      adr_i = 10'(adr + 7);
      tga_i = 8'hFF;
      n_checks++;
      if ((ack | err) !== 1'(i <= tga)) begin
        n_fail++;
        $display("FAIL resp_cycle%0d: got %0b, required %0b", i, (ack | err), (i <= tga));
      end
    end
    stb = 1'b0;
    n_checks++;
    if (stall !== 1'(nstb > tga)) begin
      n_fail++;
      $display("FAIL stall_end: got %0b, required %0b", stall, (nstb > tga));
    end
    cyc = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_idle: got %0b, required 0", stall);
    end
  endtask

  task automatic drain_check(input string name);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d responses missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (ack !== 1'b0 || err !== 1'b0 || stall !== 1'b0 || dat_o !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%0b err=%0b stall=%0b dat=%02h, required all 0",
               ack, err, stall, dat_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    wdata[0] = 8'hA1; wdata[1] = 8'hB2; wdata[2] = 8'hC3; wdata[3] = 8'hD4;
    do_burst(1'b1, 1'b1, 2, 3, 4);
    do_burst(1'b0, 1'b1, 2, 3, 4);
    drain_check("write_read");
  endtask

  task automatic test_out_of_range();
    do_burst(1'b0, 1'b1, 14, 3, 6);
    drain_check("out_of_range");
  endtask

  task automatic test_tgc_zero();
    wdata[0] = 8'h55;
    do_burst(1'b1, 1'b0, 0, 0, 1);
    do_burst(1'b0, 1'b1, 0, 0, 1);
    drain_check("tgc_zero");
  endtask

  task automatic test_over_strobe();
    do_burst(1'b0, 1'b1, 4, 1, 4);
    drain_check("over_strobe");
  endtask

  task automatic test_abort();
    wdata[0] = 8'h31; wdata[1] = 8'h32; wdata[2] = 8'h33; wdata[3] = 8'h34;
    do_burst(1'b1, 1'b1, 8, 3, 2);
    wdata[0] = 8'h77;
    do_burst(1'b1, 1'b1, 10, 0, 1);
    do_burst(1'b0, 1'b1, 8, 3, 4);
    drain_check("abort");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) wdata[i] = 8'(8'h40 + 3 * i);
    do_burst(1'b1, 1'b1, 0, 15, 16);
    do_burst(1'b0, 1'b1, 0, 15, 16);
    drain_check("back_to_back");
  endtask

  task automatic test_async_reset();
    cyc   = 1'b1;
    stb   = 1'b1;
    we_i  = 1'b1;
    tgc_i = 1'b1;
    adr_i = 10'd0;
    tga_i = 8'd3;
    dat_i = 8'h11;
    sb.push_back({1'b0, 1'b0, 1'b1, 8'h00});
    @(posedge clk); #1;
    dat_i = 8'h22;
    sb.push_back({1'b0, 1'b0, 1'b1, 8'h00});
    @(posedge clk); #1;
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_ack: got %0b, required 1", ack);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ack !== 1'b0 || err !== 1'b0 || stall !== 1'b0 || dat_o !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset: ack=%0b err=%0b stall=%0b dat=%02h, required all 0",
               ack, err, stall, dat_o);
    end
    sb.delete();
    for (int i = 0; i < Depth; i++) model_mem[i] = 8'h00;
    cyc = 1'b0;
    stb = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_burst(1'b0, 1'b1, 0, 15, 16);
    drain_check("async_reset");
  endtask

  initial begin
    rst   = 1'b1;
    cyc   = 1'b0;
    stb   = 1'b0;
    we_i  = 1'b0;
    adr_i = '0;
    tga_i = '0;
    dat_i = '0;
    tgc_i = 1'b0;
    for (int i = 0; i < Depth; i++) model_mem[i] = 8'h00;
    for (int i = 0; i < 16; i++) wdata[i] = 8'h00;

    test_reset();
    test_write_read();
    test_out_of_range();
    test_tgc_zero();
    test_over_strobe();
    test_abort();
    test_back_to_back();
    test_async_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wbs_reg_responder.md
WBS_REG_RESPONDER -- requirements
Module: wbs_reg_responder

Interface
REQ-001 The block SHALL have parameter REG_DEPTH, default 16, giving the number of 8-bit registers, legal range 1..1024.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The block SHALL have port wbs_cyc_i, input, 1 bit: Wishbone cycle.
REQ-005 The block SHALL have port wbs_stb_i, input, 1 bit: Wishbone strobe.
REQ-006 The block SHALL have port wbs_we_i, input, 1 bit: '1' write, '0' read.
REQ-007 The block SHALL have port wbs_adr_i, input, 10 bits: start address, sampled on the first beat only.
REQ-008 The block SHALL have port wbs_tga_i, input, 8 bits: burst length minus one, sampled on the first beat only.
REQ-009 The block SHALL have port wbs_dat_i, input, 8 bits: write data.
REQ-010 The block SHALL have port wbs_tgc_i, input, 1 bit: '1' register access (served), '0' SPI transfer (rejected).
REQ-011 The block SHALL have port wbs_dat_o, output, 8 bits: read data, valid with wbs_ack_o.
REQ-012 The block SHALL have port wbs_stall_o, output, 1 bit: stall; a strobe is accepted only when wbs_stall_o='0'.
REQ-013 The block SHALL have port wbs_ack_o, output, 1 bit: beat acknowledge.
REQ-014 The block SHALL have port wbs_err_o, output, 1 bit: beat error.

Function
REQ-015 Beat acceptance SHALL occur on a rising edge with wbs_cyc_i=1, wbs_stb_i=1 and wbs_stall_o=0.
REQ-016 The state machine SHALL have states IDLE, BURST and DONE.
REQ-017 IDLE: wbs_stall_o=0; the first accepted beat SHALL latch address, wbs_tga_i, wbs_we_i and wbs_tgc_i, then go to BURST, or to DONE if wbs_tga_i=0.
REQ-018 BURST: wbs_stall_o=0; each accepted beat SHALL decrement the remaining-beat counter; the beat that completes tga+1 beats SHALL move the block to DONE.
REQ-019 DONE: wbs_stall_o=1; the state SHALL persist until wbs_cyc_i=0, then return to IDLE; strobes beyond the burst length are never accepted.
REQ-020 wbs_cyc_i=0 in BURST SHALL abort to IDLE immediately; no response is issued for unaccepted beats.
REQ-021 Beat n (0-based) SHALL address start+n, computed 11 bits wide with no wrap-around.
REQ-022 Every accepted beat SHALL receive exactly one single-cycle response on the next cycle: wbs_ack_o or wbs_err_o, never both.
REQ-023 A beat SHALL receive wbs_err_o=1 when its address >= REG_DEPTH or the latched wbs_tgc_i=0; an errored beat writes nothing and wbs_dat_o=0.
REQ-024 A write beat with ack SHALL update the register at its address on the acceptance edge.
REQ-025 A read beat with ack SHALL drive the register contents onto wbs_dat_o in the ack cycle.
REQ-026 A read immediately following a write to the same address SHALL return the new data.
REQ-027 wbs_we_i and wbs_tgc_i changing mid-burst SHALL be ignored; the latched values SHALL apply to the whole burst.
REQ-028 An error on one beat SHALL NOT terminate the burst; the remaining beats are processed normally.
REQ-029 Back-to-back accepted beats SHALL produce back-to-back responses, one beat per cycle sustained.
REQ-030 A response pending when wbs_cyc_i falls SHALL still be driven in the following cycle.

Reset
REQ-031 When rst=1, the block SHALL immediately, without waiting for clk, set state=IDLE, wbs_ack_o=0, wbs_err_o=0, wbs_stall_o=0, wbs_dat_o=0, counters=0 and all registers=0x00.
REQ-032 Reset asserted mid-burst SHALL discard pending responses; the block SHALL accept a new burst on the first edge after rst is released.

Verification
REQ-033 Write burst adr=2, tga=3, data 0xA1,0xB2,0xC3,0xD4, tgc=1 -> four acks, one per cycle; then read burst adr=2, tga=3 -> dat_o 0xA1,0xB2,0xC3,0xD4 with acks.
REQ-034 Read burst adr=14, tga=3, REG_DEPTH=16 -> ack, ack, err, err; the block sits in DONE with stall=1 until cyc=0.
REQ-035 Single write with tgc=0, adr=0, data 0x55 -> err, no ack; a subsequent read of adr 0 returns 0x00.
REQ-036 Burst tga=1 with stb held for 4 cycles -> exactly 2 responses; stall=1 from the cycle after the 2nd acceptance until cyc=0.
REQ-037 Drop cyc after 2 of 4 beats -> 2 responses only; a new single write is accepted on the next cycle with cyc=1.
REQ-038 Assert rst asynchronously mid-burst -> outputs 0 before the next clk edge; a read of all addresses afterwards returns 0x00.
